// File: rtl/approx_err_monitor.sv
// approx_err_monitor
//   Streaming error-statistics stage for segmented approximate adders.
//   Each accepted sample (in_a, in_b, in_y) is compared against the exact
//   sum. The error distance (ED) is accumulated over a window of
//   2^WINDOW_LOG2 samples: the count of samples with a nonzero ED, the
//   largest ED and the summed ED. The result is then offered as one
//   report word over a valid/ready handshake.
//
//   Optional feature macro: ERRMON_COUT_EN
//     defined   : in_cout port exists, approx = {in_cout, in_y}, and the
//                 comparison uses the full WIDTH+1-bit exact sum.
//     undefined : no in_cout port, and the comparison is modulo 2^WIDTH.
//
//   Ports
//     clk, rst                    clock, async active-high reset
//     clear                       synchronous flush of window and in-flight sample
//     in_valid / in_ready         sample handshake
//     in_a, in_b                  adder operands (unsigned)
//     in_y                        approximate sum from the adder under test
//     in_cout                     approximate carry-out (ERRMON_COUT_EN only)
//     out_valid / out_ready       report handshake
//     out_err_cnt                 samples in the window with ED != 0
//     out_max_ed                  largest ED in the window
//     out_sum_ed                  sum of ED over the window (cannot overflow)
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ACCUM   | accepting samples, accumulating statistics
//   DRAIN   | one cycle so stage 2 absorbs the last accepted sample
//   REPORT  | report presented, waiting for out_ready

module approx_err_monitor #(
  parameter int WIDTH       = 32,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           in_y,
`ifdef ERRMON_COUT_EN
  input  logic                       in_cout,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WINDOW_LOG2:0]       out_err_cnt,
  output logic [WIDTH:0]             out_max_ed,
  output logic [WIDTH+WINDOW_LOG2:0] out_sum_ed
);

  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam int SUM_W = WIDTH + 1 + WINDOW_LOG2;
  localparam int N     = 1 << WINDOW_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_s1_valid;
  logic [WIDTH:0]     r_s1_ed;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [WIDTH:0]     r_max_ed;
  logic [SUM_W-1:0]   r_sum_ed;

  logic               w_accept;
  logic               w_out_valid;
  logic               w_handshake;
  logic [WIDTH:0]     w_ed;

  // in_ready must read 0 for the whole time rst is high, not only after
  // the first edge, so rst gates it directly.
  assign in_ready = (r_state == ST_ACCUM) && !rst;
  assign w_accept = in_valid && in_ready;

`ifdef ERRMON_COUT_EN
  logic [WIDTH:0] w_exact;
  logic [WIDTH:0] w_approx;

  assign w_exact  = {1'b0, in_a} + {1'b0, in_b};
  assign w_approx = {in_cout, in_y};
  assign w_ed     = (w_exact >= w_approx) ? (w_exact - w_approx)
                                          : (w_approx - w_exact);
`else
  logic [WIDTH-1:0] w_exact_t;
  logic [WIDTH-1:0] w_diff;

  // The carry out of the exact sum is dropped, so the comparison is
  // modulo 2^WIDTH.
  assign w_exact_t = in_a + in_b;
  assign w_diff    = (w_exact_t >= in_y) ? (w_exact_t - in_y)
                                         : (in_y - w_exact_t);
  assign w_ed      = {1'b0, w_diff};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && (r_cnt == CNT_LAST)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
    // clear wins over any accept or report handshake in the same cycle.
    if (clear) w_state_nxt = ST_ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_err_cnt  <= '0;
      r_max_ed   <= '0;
      r_sum_ed   <= '0;
    end else if (clear) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_err_cnt  <= '0;
      r_max_ed   <= '0;
      r_sum_ed   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed <= w_ed;
        r_cnt   <= r_cnt + CNT_ONE;
      end
      // A handshake only happens in REPORT, where stage 1 is empty, so the
      // two branches never compete for the same sample.
      if (w_handshake) begin
        r_cnt     <= '0;
        r_err_cnt <= '0;
        r_max_ed  <= '0;
        r_sum_ed  <= '0;
      end else if (r_s1_valid) begin
        r_err_cnt <= r_err_cnt + {{WINDOW_LOG2{1'b0}}, (r_s1_ed != '0)};
        if (r_s1_ed > r_max_ed) r_max_ed <= r_s1_ed;
        r_sum_ed  <= r_sum_ed + {{WINDOW_LOG2{1'b0}}, r_s1_ed};
      end
    end
  end

  assign out_valid   = w_out_valid;
  assign out_err_cnt = r_err_cnt;
  assign out_max_ed  = r_max_ed;
  assign out_sum_ed  = r_sum_ed;

endmodule

// File: tb/tb_approx_err_monitor.sv
module tb_approx_err_monitor;

  localparam int WIDTH = 32;
  localparam int WL2   = 2;
  localparam int NS    = 1 << WL2;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH-1:0]  in_y;
  logic              in_cout;
  logic              out_valid;
  logic              out_ready;
  logic [WL2:0]      out_err_cnt;
  logic [WIDTH:0]    out_max_ed;
  logic [WIDTH+WL2:0] out_sum_ed;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] wa [NS];
  logic [WIDTH-1:0] wb [NS];
  logic [WIDTH-1:0] wy [NS];
  logic             wc [NS];

  approx_err_monitor #(.WIDTH(WIDTH), .WINDOW_LOG2(WL2)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_y        (in_y),
`ifdef ERRMON_COUT_EN
    .in_cout     (in_cout),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_err_cnt (out_err_cnt),
    .out_max_ed  (out_max_ed),
    .out_sum_ed  (out_sum_ed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ED per sample from plain 64-bit arithmetic, then window stats.
  task automatic model(output logic [63:0] m_cnt, output logic [63:0] m_max,
                       output logic [63:0] m_sum);
    longint unsigned ex, ap, ed;
    m_cnt = 0; m_max = 0; m_sum = 0;
    for (int i = 0; i < NS; i++) begin
      ex = 64'(wa[i]) + 64'(wb[i]);
`ifdef ERRMON_COUT_EN
      ap = 64'(wy[i]) + (64'(wc[i]) << WIDTH);
`else
      ex = ex % (64'd1 << WIDTH);
      ap = 64'(wy[i]);
`endif
      ed = (ex >= ap) ? ex - ap : ap - ex;
      if (ed != 0) m_cnt = m_cnt + 1;
      if (ed > m_max) m_max = ed;
      m_sum = m_sum + ed;
    end
  endtask

  task automatic set_s(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] y, input logic c);
    wa[i] = a; wb[i] = b; wy[i] = y; wc[i] = c;
  endtask

  // mode 0: all exact; mode 1: mix of exact, bit-flip, random, wrong carry.
  task automatic fill_rand(input int mode);
    logic [32:0] s;
    int k;
    for (int i = 0; i < NS; i++) begin
      wa[i] = $urandom;
      wb[i] = $urandom;
      s = {1'b0, wa[i]} + {1'b0, wb[i]};
      k = (mode == 0) ? 0 : int'($urandom_range(0, 3));
      case (k)
        1:       begin wy[i] = s[31:0] ^ (32'd1 << $urandom_range(0, 31)); wc[i] = s[32]; end
        2:       begin wy[i] = $urandom; wc[i] = 1'($urandom_range(0, 1)); end
        3:       begin wy[i] = s[31:0]; wc[i] = ~s[32]; end
        default: begin wy[i] = s[31:0]; wc[i] = s[32]; end
      endcase
    end
  endtask

  task automatic chk_report(input string tag, input logic [63:0] e_cnt,
                            input logic [63:0] e_max, input logic [63:0] e_sum);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_err_cnt"}, out_err_cnt, e_cnt);
    chk({tag, "_max_ed"}, out_max_ed, e_max);
    chk({tag, "_sum_ed"}, out_sum_ed, e_sum);
  endtask

  // Sends wa/wb/wy/wc as one window and checks timing and the report.
  task automatic run_window(input string tag, input int bp, input bit gaps,
                            input bit has_exp, input logic [63:0] x_cnt,
                            input logic [63:0] x_max, input logic [63:0] x_sum);
    logic [63:0] e_cnt, e_max, e_sum;
    int g;
    model(e_cnt, e_max, e_sum);
    if (has_exp) begin
      e_cnt = x_cnt; e_max = x_max; e_sum = x_sum;
    end
    out_ready = (bp == 0);
    for (int i = 0; i < NS; i++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 2));
        in_valid = 1'b0;
        for (int j = 0; j < g; j++) begin
          tick();
          chk({tag, "_idle_ready"}, in_ready, 1);
          chk({tag, "_idle_valid"}, out_valid, 0);
        end
      end
      in_valid = 1'b1;
      in_a = wa[i]; in_b = wb[i]; in_y = wy[i]; in_cout = wc[i];
      chk({tag, "_accept_ready"}, in_ready, 1);
      tick();
    end
    // DRAIN cycle: junk sample must be ignored.
    in_a = $urandom; in_b = $urandom; in_y = $urandom;
    chk({tag, "_drain_ready"}, in_ready, 0);
    chk({tag, "_drain_valid"}, out_valid, 0);
    tick();
    chk_report({tag, "_rep"}, e_cnt, e_max, e_sum);
    for (int j = 0; j < bp; j++) begin
      tick();
      chk_report({tag, "_hold"}, e_cnt, e_max, e_sum);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_post_ready"}, in_ready, 1);
    chk({tag, "_post_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [63:0] e_cnt, e_max, e_sum;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_y = '0; in_cout = 1'b0;
    for (int i = 0; i < NS; i++) set_s(i, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", out_err_cnt, 0);
    chk("rst_max_ed", out_max_ed, 0);
    chk("rst_sum_ed", out_sum_ed, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Exact stream
    fill_rand(0);
    run_window("exact", 0, 1'b0, 1'b1, 0, 0, 0);

    // Error stream
    set_s(0, 32'hF, 32'h1, 32'h0, 1'b0);
    set_s(1, 32'd5, 32'd5, 32'd10, 1'b0);
    set_s(2, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 1'b0);
    set_s(3, 32'd2, 32'd2, 32'd1, 1'b0);
    run_window("errs", 0, 1'b0, 1'b1, 3, 64'h1000_0000, 64'h1000_0013);

    // Backpressure, then back-to-back exact window
    fill_rand(1);
    run_window("bp", 5, 1'b0, 1'b0, 0, 0, 0);
    fill_rand(0);
    run_window("after_bp", 0, 1'b0, 1'b1, 0, 0, 0);

    // Clear mid-window together with an accept
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 32'hF; in_b = 32'h1; in_y = 32'h0; in_cout = 1'b0;
      chk("clr_pre_ready", in_ready, 1);
      tick();
    end
    clear = 1'b1;
    in_a = 32'hF; in_b = 32'h1; in_y = 32'h0;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_in_ready", in_ready, 1);
    chk("clr_out_valid", out_valid, 0);
    fill_rand(0);
    run_window("after_clr", 0, 1'b0, 1'b1, 0, 0, 0);

    // Async reset while in REPORT
    fill_rand(1);
    out_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      in_a = wa[i]; in_b = wb[i]; in_y = wy[i]; in_cout = wc[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("arst_pre_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid_drop", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    tick();
    chk("arst_err_cnt", out_err_cnt, 0);
    chk("arst_max_ed", out_max_ed, 0);
    chk("arst_sum_ed", out_sum_ed, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", in_ready, 1);
    fill_rand(1);
    run_window("after_arst", 0, 1'b0, 1'b0, 0, 0, 0);

    // Carry-out handling
    set_s(0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    set_s(1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    set_s(2, 32'd3, 32'd4, 32'd7, 1'b0);
    set_s(3, 32'd3, 32'd4, 32'd7, 1'b1);
`ifdef ERRMON_COUT_EN
    run_window("carry", 0, 1'b0, 1'b1, 2, 64'h1_0000_0000, 64'h2_0000_0000);
`else
    run_window("carry", 0, 1'b0, 1'b1, 0, 0, 0);
`endif

    // Randomized windows with idle gaps and random backpressure
    for (int r = 0; r < 8; r++) begin
      fill_rand(1);
      run_window("rand", int'($urandom_range(0, 2)), 1'b1, 1'b0, 0, 0, 0);
    end

    model(e_cnt, e_max, e_sum);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
